// File: rtl/qspi_line_fill_pkg.sv
// qspi_line_fill_pkg
// Definitions shared by the line-fill front end and the QSPI controller:
// default line geometry, the arbiter/transfer state encoding, and the
// nibble-to-bit mapping of a cache line.
// A line is carried as LINE_LENGTH bytes with byte 0 in bits 7:0. Each byte
// travels high nibble first. Nibble k therefore belongs to byte k/2 and sits
// in the upper half of that byte when k is even.
package qspi_line_fill_pkg;

  localparam int LINE_LENGTH_DEF = 4;
  localparam int PA_DEF          = 24;

  localparam int NIB_W      = 4;
  localparam int NIB_HI_OFS = 4;   // bit offset of the high nibble inside a byte
  localparam int NIB_LO_OFS = 0;   // bit offset of the low nibble inside a byte

  // Value of last_grant: the most recent dual-request winner.
  localparam logic GRANT_I = 1'b1;
  localparam logic GRANT_D = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    ACK  = 2'd3
  } state_t;

  // LSB position of nibble k within the line vector.
  function automatic int nib_lsb(input int k);
    return (k / 2) * 8 + (((k % 2) == 0) ? NIB_HI_OFS : NIB_LO_OFS);
  endfunction

endpackage

// File: rtl/qspi_nib_line.sv
// qspi_nib_line
// Cache-line register that is filled or drained one nibble at a time.
// Ports:
//   clk, reset  clock and asynchronous active-high reset (clears the line)
//   load        parallel load of load_data (takes priority over nib_we)
//   load_data   full line, byte 0 in bits 7:0
//   nib_we      write nib_wdata into the nibble selected by nib_idx
//   nib_idx     nibble index in transfer order; values >= 2*LINE_LENGTH select nothing
//   nib_wdata   nibble to write
//   line        current line contents
//   nib_rdata   nibble selected by nib_idx, 0 when out of range
import qspi_line_fill_pkg::*;

module qspi_nib_line #(
  parameter  int LINE_LENGTH = LINE_LENGTH_DEF,
  localparam int NIBS        = 2 * LINE_LENGTH,
  localparam int CW          = $clog2(2 * LINE_LENGTH + 1),
  localparam int LW          = LINE_LENGTH * 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [LW-1:0] load_data,
  input  logic          nib_we,
  input  logic [CW-1:0] nib_idx,
  input  logic [3:0]    nib_wdata,
  output logic [LW-1:0] line,
  output logic [3:0]    nib_rdata
);

  logic [3:0] nib_arr [NIBS];

  // One 4-bit register per nibble, placed at its position in the line.
  for (genvar gi = 0; gi < NIBS; gi++) begin : g_nib
    localparam int LSB = nib_lsb(gi);
    logic [3:0] nib_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        nib_reg <= '0;
      end else if (load) begin
        nib_reg <= load_data[LSB +: NIB_W];
      end else if (nib_we && (nib_idx == CW'(gi))) begin
        nib_reg <= nib_wdata;
      end
    end

    assign line[LSB +: NIB_W] = nib_reg;
    assign nib_arr[gi]        = nib_reg;
  end

  always_comb begin
    nib_rdata = '0;
    for (int i = 0; i < NIBS; i++) begin
      if (nib_idx == CW'(i)) begin
        nib_rdata = nib_arr[i];
      end
    end
  end

endmodule

// File: rtl/qspi_line_fill.sv
// qspi_line_fill
// Arbitrates icache fills and dcache fills/write-backs onto one QSPI
// controller, assembles read nibbles into a line, and serialises write-back
// lines into nibbles.
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   ireq/iaddr/imem/iack         icache fill request (level) and ack pulse
//   dreq/dwr/daddr/dmem/dwdata   dcache request (level), dwr=1 write-back
//   dack                         dcache ack pulse
//   rdata                        filled line, held until the next grant
//   req/i_d/mem/write/paddr      registered request to the controller
//   wstrobe_i/wstrobe_d/rnib     read nibble strobes and nibble from controller
//   rstrobe_d/dwrite             controller takes dwrite on rstrobe_d
//   err                          sticky: stray or wrong-kind strobe seen
import qspi_line_fill_pkg::*;

module qspi_line_fill #(
  parameter  int LINE_LENGTH = LINE_LENGTH_DEF,
  parameter  int PA          = PA_DEF,
  localparam int LAW         = PA - $clog2(LINE_LENGTH),
  localparam int LW          = LINE_LENGTH * 8,
  localparam int CW          = $clog2(2 * LINE_LENGTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ireq,
  input  logic [LAW-1:0] iaddr,
  input  logic           imem,
  output logic           iack,
  input  logic           dreq,
  input  logic           dwr,
  input  logic [LAW-1:0] daddr,
  input  logic           dmem,
  input  logic [LW-1:0]  dwdata,
  output logic           dack,
  output logic [LW-1:0]  rdata,
  output logic           req,
  output logic           i_d,
  output logic           mem,
  output logic           write,
  output logic [LAW-1:0] paddr,
  input  logic           wstrobe_i,
  input  logic           wstrobe_d,
  input  logic [3:0]     rnib,
  input  logic           rstrobe_d,
  output logic [3:0]     dwrite,
  output logic           err
);

  // The strobe carrying index TERM is the controller's trailing strobe.
  localparam logic [CW-1:0] TERM = CW'(2 * LINE_LENGTH);

  state_t         state_reg, state_next;
  logic           req_reg, req_next;
  logic           i_d_reg, i_d_next;
  logic           mem_reg, mem_next;
  logic           write_reg, write_next;
  logic [LAW-1:0] paddr_reg, paddr_next;
  logic [CW-1:0]  nib_cnt_reg, nib_cnt_next;
  logic           iack_reg, iack_next;
  logic           dack_reg, dack_next;
  logic           err_reg, err_next;
  logic           last_grant_reg, last_grant_next;

  logic           line_load;
  logic           nib_we;
  logic [3:0]     nib_rdata;
  logic           grant_d;
  logic           stb_any;
  logic           stb_exp;
  logic           stb_wrong;

  qspi_nib_line #(
    .LINE_LENGTH (LINE_LENGTH)
  ) u_line (
    .clk       (clk),
    .reset     (reset),
    .load      (line_load),
    .load_data (dwdata),
    .nib_we    (nib_we),
    .nib_idx   (nib_cnt_reg),
    .nib_wdata (rnib),
    .line      (rdata),
    .nib_rdata (nib_rdata)
  );

  // dcache wins a dual request unless it won the previous one.
  assign grant_d = dreq && (!ireq || (last_grant_reg == GRANT_I));

  // Only one strobe kind belongs to the transaction in flight; anything
  // else on the strobe lines is a protocol error.
  assign stb_any   = wstrobe_i | wstrobe_d | rstrobe_d;
  assign stb_exp   = write_reg ? rstrobe_d : (i_d_reg ? wstrobe_i : wstrobe_d);
  assign stb_wrong = write_reg ? (wstrobe_i | wstrobe_d)
                               : (i_d_reg ? (wstrobe_d | rstrobe_d)
                                          : (wstrobe_i | rstrobe_d));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      req_reg        <= 1'b0;
      i_d_reg        <= 1'b0;
      mem_reg        <= 1'b0;
      write_reg      <= 1'b0;
      paddr_reg      <= '0;
      nib_cnt_reg    <= '0;
      iack_reg       <= 1'b0;
      dack_reg       <= 1'b0;
      err_reg        <= 1'b0;
      last_grant_reg <= GRANT_I;
    end else begin
      state_reg      <= state_next;
      req_reg        <= req_next;
      i_d_reg        <= i_d_next;
      mem_reg        <= mem_next;
      write_reg      <= write_next;
      paddr_reg      <= paddr_next;
      nib_cnt_reg    <= nib_cnt_next;
      iack_reg       <= iack_next;
      dack_reg       <= dack_next;
      err_reg        <= err_next;
      last_grant_reg <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    req_next        = req_reg;
    i_d_next        = i_d_reg;
    mem_next        = mem_reg;
    write_next      = write_reg;
    paddr_next      = paddr_reg;
    nib_cnt_next    = nib_cnt_reg;
    iack_next       = 1'b0;
    dack_next       = 1'b0;
    err_next        = err_reg;
    last_grant_next = last_grant_reg;
    line_load       = 1'b0;
    nib_we          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (stb_any) begin
          err_next = 1'b1;
        end
        if (ireq || dreq) begin
          i_d_next     = !grant_d;
          write_next   = grant_d && dwr;
          mem_next     = grant_d ? dmem : imem;
          paddr_next   = grant_d ? daddr : iaddr;
          line_load    = grant_d && dwr;
          nib_cnt_next = '0;
          req_next     = 1'b1;
          state_next   = REQ;
          if (ireq && dreq) begin
            last_grant_next = grant_d ? GRANT_D : GRANT_I;
          end
        end
      end

      REQ: begin
        if (stb_wrong) begin
          err_next = 1'b1;
        end
        // First expected strobe is nibble 0; the controller has seen req.
        if (stb_exp) begin
          req_next     = 1'b0;
          nib_we       = !write_reg;
          nib_cnt_next = nib_cnt_reg + CW'(1);
          state_next   = XFER;
        end
      end

      XFER: begin
        if (stb_wrong) begin
          err_next = 1'b1;
        end
        if (stb_exp) begin
          if (nib_cnt_reg == TERM) begin
            state_next = ACK;
            iack_next  = i_d_reg;
            dack_next  = !i_d_reg;
          end else begin
            nib_we       = !write_reg;
            nib_cnt_next = nib_cnt_reg + CW'(1);
          end
        end
      end

      ACK: begin
        if (stb_any) begin
          err_next = 1'b1;
        end
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign req   = req_reg;
  assign i_d   = i_d_reg;
  assign mem   = mem_reg;
  assign write = write_reg;
  assign paddr = paddr_reg;
  assign iack  = iack_reg;
  assign dack  = dack_reg;
  assign err   = err_reg;

  // Write-back nibble for the current index; the trailing strobe carries 0.
  assign dwrite = (write_reg && ((state_reg == REQ) || (state_reg == XFER)) &&
                   (nib_cnt_reg != TERM)) ? nib_rdata : 4'h0;

endmodule

// File: tb/tb_qspi_line_fill.sv
// tb_qspi_line_fill
// Directed bench: plays the QSPI controller side (strobes and nibbles) and the
// two cache clients, comparing outputs with hand-computed line values.
module tb_qspi_line_fill;

  localparam int LINE_LENGTH = 4;
  localparam int PA          = 24;
  localparam int LAW         = PA - $clog2(LINE_LENGTH);
  localparam int LW          = LINE_LENGTH * 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           ireq, imem, iack;
  logic [LAW-1:0] iaddr;
  logic           dreq, dwr, dmem, dack;
  logic [LAW-1:0] daddr;
  logic [LW-1:0]  dwdata;
  logic [LW-1:0]  rdata;
  logic           req, i_d, mem, write;
  logic [LAW-1:0] paddr;
  logic           wstrobe_i, wstrobe_d, rstrobe_d;
  logic [3:0]     rnib, dwrite;
  logic           err;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  qspi_line_fill #(
    .LINE_LENGTH (LINE_LENGTH),
    .PA          (PA)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ireq      (ireq),
    .iaddr     (iaddr),
    .imem      (imem),
    .iack      (iack),
    .dreq      (dreq),
    .dwr       (dwr),
    .daddr     (daddr),
    .dmem      (dmem),
    .dwdata    (dwdata),
    .dack      (dack),
    .rdata     (rdata),
    .req       (req),
    .i_d       (i_d),
    .mem       (mem),
    .write     (write),
    .paddr     (paddr),
    .wstrobe_i (wstrobe_i),
    .wstrobe_d (wstrobe_d),
    .rnib      (rnib),
    .rstrobe_d (rstrobe_d),
    .dwrite    (dwrite),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // kind: 0 = wstrobe_i, 1 = wstrobe_d, 2 = rstrobe_d
  task automatic pulse(input int kind, input logic [3:0] nib);
    rnib      = nib;
    wstrobe_i = (kind == 0);
    wstrobe_d = (kind == 1);
    rstrobe_d = (kind == 2);
    @(posedge clk); #1;
    wstrobe_i = 1'b0;
    wstrobe_d = 1'b0;
    rstrobe_d = 1'b0;
  endtask

  // One full transaction from the controller side. nibs/dexp hold nibble k
  // at bits 4k+3:4k. inj_at >= 0 injects one wrong-kind strobe before that
  // nibble. drop releases both client requests during the ack cycle.
  task automatic xact(input string name, input int kind, input logic [35:0] nibs,
                      input logic [35:0] dexp, input logic exp_id, input logic chk_dw,
                      input int inj_at, input logic [31:0] exp_rdata, input logic drop);
    int n;
    n = 0;
    while (!req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_req_latency"}, n, 1);
    chk({name, "_grant_id"}, i_d, exp_id);
    for (int k = 0; k < 2 * LINE_LENGTH + 1; k++) begin
      if (k == inj_at) pulse((kind == 0) ? 1 : 0, 4'h7);
      if (chk_dw) chk({name, "_dwrite"}, dwrite, dexp[4*k +: 4]);
      pulse(kind, nibs[4*k +: 4]);
      if (k == 0) chk({name, "_req_drop"}, req, 0);
    end
    chk({name, "_iack"}, iack, exp_id);
    chk({name, "_dack"}, dack, !exp_id);
    chk({name, "_req_low_ack"}, req, 0);
    chk({name, "_rdata"}, rdata, exp_rdata);
    $display("xact %s id=%0d rdata=%h paddr=%h err=%0d", name, i_d, rdata, paddr, err);
    if (drop) begin
      ireq = 1'b0;
      dreq = 1'b0;
    end
    @(posedge clk); #1;
    chk({name, "_iack_end"}, iack, 0);
    chk({name, "_dack_end"}, dack, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ireq = 0; imem = 0; iaddr = '0;
    dreq = 0; dwr = 0; dmem = 0; daddr = '0; dwdata = '0;
    wstrobe_i = 0; wstrobe_d = 0; rstrobe_d = 0; rnib = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_req", req, 0);
    chk("rst_iack", iack, 0);
    chk("rst_dack", dack, 0);
    chk("rst_err", err, 0);
    chk("rst_write", write, 0);
    chk("rst_i_d", i_d, 0);
    chk("rst_mem", mem, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_dwrite", dwrite, 0);

    // Single icache fill.
    iaddr = 22'h12345; imem = 1'b1; ireq = 1'b1;
    xact("ifill", 0, 36'hF87654321, 36'h0, 1'b1, 1'b0, -1, 32'h78563412, 1'b1);
    chk("ifill_paddr", paddr, 22'h12345);
    chk("ifill_mem", mem, 1);
    chk("ifill_write", write, 0);
    chk("ifill_err", err, 0);

    // dcache write-back; byte 0 = EF goes out E then F.
    daddr = 22'h3ABCD; dmem = 1'b0; dwr = 1'b1; dwdata = 32'hDEADBEEF; dreq = 1'b1;
    xact("dwb", 2, 36'h0, 36'h0EDDAEBFE, 1'b0, 1'b1, -1, 32'hDEADBEEF, 1'b1);
    chk("dwb_write", write, 1);
    chk("dwb_paddr", paddr, 22'h3ABCD);
    chk("dwb_mem", mem, 0);

    // Both requesters held: dcache, icache, dcache.
    dwr = 1'b0; iaddr = 22'h00111; daddr = 22'h00222; imem = 1'b0; dmem = 1'b1;
    ireq = 1'b1; dreq = 1'b1;
    xact("dual1", 1, 36'h04321DCBA, 36'h0, 1'b0, 1'b0, -1, 32'h3412CDAB, 1'b0);
    chk("dual1_paddr", paddr, 22'h00222);
    xact("dual2", 0, 36'h069F0A5A5, 36'h0, 1'b1, 1'b0, -1, 32'h960F5A5A, 1'b0);
    chk("dual2_paddr", paddr, 22'h00111);
    xact("dual3", 1, 36'h5E73C00FF, 36'h0, 1'b0, 1'b0, -1, 32'h7EC300FF, 1'b1);
    chk("dual_err", err, 0);

    // Stray strobe in IDLE.
    pulse(1, 4'h9);
    chk("stray_err", err, 1);
    chk("stray_rdata", rdata, 32'h7EC300FF);
    iaddr = 22'h00ABC; ireq = 1'b1;
    xact("after_stray", 0, 36'hF87654321, 36'h0, 1'b1, 1'b0, -1, 32'h78563412, 1'b1);
    chk("err_sticky", err, 1);

    // Asynchronous reset after nibble 3.
    ireq = 1'b1;
    @(posedge clk); #1;
    pulse(0, 4'h1);
    pulse(0, 4'h2);
    pulse(0, 4'h3);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_req", req, 0);
    chk("arst_iack", iack, 0);
    chk("arst_dack", dack, 0);
    chk("arst_err", err, 0);
    chk("arst_rdata", rdata, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    xact("post_rst", 0, 36'h013579BDF, 36'h0, 1'b1, 1'b0, -1, 32'h3175B9FD, 1'b1);
    chk("post_rst_err", err, 0);

    // dcache fill with one wrong-kind (icache) strobe injected.
    daddr = 22'h2AAAA; dmem = 1'b1; dwr = 1'b0; dreq = 1'b1;
    xact("dfill_inj", 1, 36'h02468ACE0, 36'h0, 1'b0, 1'b0, 4, 32'h4286CA0E, 1'b1);
    chk("inj_err", err, 1);
    chk("inj_mem", mem, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
